// File: rtl/mf_cfg_sequencer_if.sv
// Memory-bus link between the configuration sequencer (master) and the
// median filter register port (slave).
interface mf_cfg_sequencer_if #(
    parameter int DW_MA = 8,
    parameter int DW_MD = 16
);
    logic [DW_MA-1:0] adr;
    logic [DW_MD-1:0] wdt;
    logic [DW_MD-1:0] rdt;
    logic             val;

    modport master (output adr, output wdt, output val, input rdt);
    modport slave  (input adr, input wdt, input val, output rdt);
endinterface

// File: rtl/mf_cfg_sequencer.sv
// Configuration sequencer for the median filter: waits for a frame gap,
// disables the filter, writes width/height, verifies them by readback with
// bounded retries, then restores the requested enable. A filter error
// replays the last accepted geometry.
module mf_cfg_sequencer #(
    parameter int DW_MA      = 8,
    parameter int DW_MD      = 16,
    parameter int ADR_CTRL   = 0,
    parameter int ADR_WIDTH  = 1,
    parameter int ADR_HEIGHT = 2,
    parameter int RD_LAT     = 1,
    parameter int MAX_WIDTH  = 640,
    parameter int MAX_HEIGHT = 480,
    parameter int MAX_RETRY  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_req,
    input  logic [DW_MD-1:0]     cfg_width,
    input  logic [DW_MD-1:0]     cfg_height,
    input  logic                 cfg_en,
    input  logic                 frame_busy,
    input  logic                 filt_error,
    mf_cfg_sequencer_if.master   m_mb,
    output logic                 busy,
    output logic                 done,
    output logic                 cfg_err,
    output logic [1:0]           err_code
);

    localparam logic [DW_MA-1:0] A_CTRL   = DW_MA'(ADR_CTRL);
    localparam logic [DW_MA-1:0] A_WIDTH  = DW_MA'(ADR_WIDTH);
    localparam logic [DW_MA-1:0] A_HEIGHT = DW_MA'(ADR_HEIGHT);
    localparam logic [DW_MD-1:0] W_MAX    = DW_MD'(MAX_WIDTH);
    localparam logic [DW_MD-1:0] H_MAX    = DW_MD'(MAX_HEIGHT);
    localparam logic [2:0]       RD_LAST  = 3'(RD_LAT);
    localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_GEOMETRY = 2'd1;
    localparam logic [1:0] ERR_READBACK = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_FB, S_WR_DIS, S_WR_W, S_WR_H, S_RD_W, S_RD_H, S_WR_EN
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       phase_q, phase_d;
    logic [3:0]       retry_q, retry_d;
    logic [DW_MD-1:0] wid_q, wid_d;
    logic [DW_MD-1:0] hgt_q, hgt_d;
    logic             en_q, en_d;
    logic             have_cfg_q, have_cfg_d;
    logic             done_q, done_d;
    logic             cfg_err_q, cfg_err_d;
    logic [1:0]       err_code_q, err_code_d;

    function automatic logic geom_legal(input logic [DW_MD-1:0] w,
                                        input logic [DW_MD-1:0] h);
        return (w != '0) && (w <= W_MAX) && (h != '0) && (h <= H_MAX);
    endfunction

    // State and captured-configuration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            retry_q    <= '0;
            wid_q      <= '0;
            hgt_q      <= '0;
            en_q       <= 1'b0;
            have_cfg_q <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            retry_q    <= retry_d;
            wid_q      <= wid_d;
            hgt_q      <= hgt_d;
            en_q       <= en_d;
            have_cfg_q <= have_cfg_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
            err_code_q <= err_code_d;
        end
    end

    // Next-state logic: request acceptance, write/read pacing, retry policy.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        retry_d    = retry_q;
        wid_d      = wid_q;
        hgt_d      = hgt_q;
        en_d       = en_q;
        have_cfg_d = have_cfg_q;
        done_d     = 1'b0;
        cfg_err_d  = cfg_err_q;
        err_code_d = err_code_q;

        case (state_q)
            S_IDLE: begin
                phase_d = '0;
                if (cfg_req) begin
                    if (!geom_legal(cfg_width, cfg_height)) begin
                        cfg_err_d  = 1'b1;
                        err_code_d = ERR_GEOMETRY;
                    end else begin
                        wid_d      = cfg_width;
                        hgt_d      = cfg_height;
                        en_d       = cfg_en;
                        have_cfg_d = 1'b1;
                        cfg_err_d  = 1'b0;
                        err_code_d = ERR_NONE;
                        retry_d    = '0;
                        state_d    = S_WAIT_FB;
                    end
                end else if (filt_error && have_cfg_q) begin
                    retry_d = '0;
                    state_d = S_WAIT_FB;
                end
            end
            S_WAIT_FB: begin
                if (!frame_busy) begin
                    phase_d = '0;
                    state_d = S_WR_DIS;
                end
            end
            S_WR_DIS, S_WR_W, S_WR_H: begin
                if (phase_q == '0) begin
                    phase_d = 3'd1;
                end else begin
                    phase_d = '0;
                    case (state_q)
                        S_WR_DIS: state_d = S_WR_W;
                        S_WR_W:   state_d = S_WR_H;
                        default:  state_d = S_RD_W;
                    endcase
                end
            end
            S_RD_W, S_RD_H: begin
                if (phase_q != RD_LAST) begin
                    phase_d = phase_q + 3'd1;
                end else begin
                    phase_d = '0;
                    if (m_mb.rdt == ((state_q == S_RD_W) ? wid_q : hgt_q)) begin
                        state_d = (state_q == S_RD_W) ? S_RD_H : S_WR_EN;
                    end else if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 4'd1;
                        state_d = S_WR_W;
                    end else begin
                        // Filter stays disabled; the host must intervene.
                        retry_d    = '0;
                        cfg_err_d  = 1'b1;
                        err_code_d = ERR_READBACK;
                        state_d    = S_IDLE;
                    end
                end
            end
            S_WR_EN: begin
                if (phase_q == '0) begin
                    phase_d = 3'd1;
                end else begin
                    phase_d = '0;
                    retry_d = '0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus drive decoded from state: strobe on the first write cycle, address
    // and data held through the gap cycle and for the whole read latency.
    always_comb begin
        m_mb.val = 1'b0;
        m_mb.adr = '0;
        m_mb.wdt = '0;
        case (state_q)
            S_WR_DIS: begin
                m_mb.adr = A_CTRL;
                m_mb.val = (phase_q == '0);
            end
            S_WR_W: begin
                m_mb.adr = A_WIDTH;
                m_mb.wdt = wid_q;
                m_mb.val = (phase_q == '0);
            end
            S_WR_H: begin
                m_mb.adr = A_HEIGHT;
                m_mb.wdt = hgt_q;
                m_mb.val = (phase_q == '0);
            end
            S_RD_W:  m_mb.adr = A_WIDTH;
            S_RD_H:  m_mb.adr = A_HEIGHT;
            S_WR_EN: begin
                m_mb.adr = A_CTRL;
                m_mb.wdt = {{(DW_MD-1){1'b0}}, en_q};
                m_mb.val = (phase_q == '0);
            end
            default: ;
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign cfg_err  = cfg_err_q;
    assign err_code = err_code_q;

endmodule

// File: tb/tb_mf_cfg_sequencer.sv
// Bench for mf_cfg_sequencer: register-slave model, table of directed
// requests, hand-written recovery/reset sequences and randomized requests
// checked against a transaction-level reference model.
module tb_mf_cfg_sequencer;
    localparam int DW_MA = 8, DW_MD = 16, RD_LAT = 1;
    localparam int MAX_WIDTH = 640, MAX_HEIGHT = 480, MAX_RETRY = 3;

    logic clk = 1'b0;
    logic rst, cfg_req, cfg_en, frame_busy, filt_error;
    logic [DW_MD-1:0] cfg_width, cfg_height;
    logic busy, done, cfg_err;
    logic [1:0] err_code;
    logic corrupt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mf_cfg_sequencer_if #(.DW_MA(DW_MA), .DW_MD(DW_MD)) mb ();

    mf_cfg_sequencer #(
        .DW_MA(DW_MA), .DW_MD(DW_MD), .RD_LAT(RD_LAT),
        .MAX_WIDTH(MAX_WIDTH), .MAX_HEIGHT(MAX_HEIGHT), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk(clk), .rst(rst), .cfg_req(cfg_req), .cfg_width(cfg_width),
        .cfg_height(cfg_height), .cfg_en(cfg_en), .frame_busy(frame_busy),
        .filt_error(filt_error), .m_mb(mb), .busy(busy), .done(done),
        .cfg_err(cfg_err), .err_code(err_code)
    );

    // Register slave: writes land on the strobe edge, reads return one cycle
    // after the address, optionally off by one to force readback mismatches.
    logic [DW_MD-1:0] regs [0:3];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            mb.rdt <= '0;
        end else begin
            if (mb.val) regs[mb.adr[1:0]] <= mb.wdt;
            mb.rdt <= regs[mb.adr[1:0]] + DW_MD'(corrupt);
        end
    end

    // Reference model state: last accepted configuration and error flags.
    bit m_have;
    bit m_err;
    logic [1:0] m_code;
    logic [DW_MD-1:0] m_w, m_h;
    bit m_en;
    int exp_adr[$], exp_wdt[$];
    int got_adr[$], got_wdt[$], got_n[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic model_reset();
        m_have = 0; m_err = 0; m_code = 0; m_w = 0; m_h = 0; m_en = 0;
    endtask

    // Transaction-level model: decides whether a sequence runs, the list of
    // bus writes it must issue, its outcome and its length in cycles.
    task automatic model_seq(input bit req, input bit ferr, input logic [DW_MD-1:0] w,
                             input logic [DW_MD-1:0] h, input bit en, input int fb,
                             input bit cor, output bit e_run, output bit e_done,
                             output int e_lat);
        int attempts;
        exp_adr.delete(); exp_wdt.delete();
        e_run = 0; e_done = 0; e_lat = 0;
        if (req) begin
            if (w == 0 || w > MAX_WIDTH || h == 0 || h > MAX_HEIGHT) begin
                m_err = 1; m_code = 1;
                return;
            end
            m_w = w; m_h = h; m_en = en; m_have = 1; m_err = 0; m_code = 0;
            e_run = 1;
        end else if (ferr && m_have) begin
            e_run = 1;
        end
        if (!e_run) return;
        attempts = cor ? MAX_RETRY + 1 : 1;
        exp_adr.push_back(0); exp_wdt.push_back(0);
        for (int a = 0; a < attempts; a++) begin
            exp_adr.push_back(1); exp_wdt.push_back(int'(m_w));
            exp_adr.push_back(2); exp_wdt.push_back(int'(m_h));
        end
        if (cor) begin
            // each failed attempt: width write, height write, width read
            m_err = 1; m_code = 2;
            e_lat = 1 + fb + 2 + attempts * (2 + 2 + RD_LAT + 1);
        end else begin
            exp_adr.push_back(0); exp_wdt.push_back(int'(m_en));
            e_done = 1;
            e_lat = 1 + fb + 3 * 2 + 2 * (RD_LAT + 1) + 2;
        end
    endtask

    // Drive one request/error pulse and observe the DUT until it goes idle.
    task automatic run_seq(input bit req, input bit ferr, input logic [DW_MD-1:0] w,
                           input logic [DW_MD-1:0] h, input bit en, input int fb,
                           input bit cor, output bit g_done, output int g_lat);
        int n;
        got_adr.delete(); got_wdt.delete(); got_n.delete();
        corrupt = cor;
        cfg_req = req; cfg_width = w; cfg_height = h; cfg_en = en;
        filt_error = ferr;
        frame_busy = (fb > 0);
        tick();
        cfg_req = 0; filt_error = 0;
        n = 0;
        while (busy && n < 2000) begin
            if (n == fb) frame_busy = 0;
            if (mb.val) begin
                got_adr.push_back(int'(mb.adr));
                got_wdt.push_back(int'(mb.wdt));
                got_n.push_back(n);
            end
            tick();
            n++;
        end
        if (n >= 2000) chk("timeout", 1, 0);
        frame_busy = 0;
        g_done = done;
        g_lat = n;
    endtask

    task automatic do_case(input string tag, input bit req, input bit ferr,
                           input logic [DW_MD-1:0] w, input logic [DW_MD-1:0] h,
                           input bit en, input int fb, input bit cor,
                           output bit g_done, output int g_lat);
        bit e_run, e_done;
        int e_lat;
        model_seq(req, ferr, w, h, en, fb, cor, e_run, e_done, e_lat);
        run_seq(req, ferr, w, h, en, fb, cor, g_done, g_lat);
        chk($sformatf("%s.done", tag), g_done, e_done);
        chk($sformatf("%s.latency", tag), g_lat, e_lat);
        chk($sformatf("%s.cfg_err", tag), cfg_err, m_err);
        chk($sformatf("%s.err_code", tag), err_code, m_code);
        chk($sformatf("%s.nwrites", tag), got_adr.size(), exp_adr.size());
        for (int i = 0; i < got_adr.size() && i < exp_adr.size(); i++) begin
            chk($sformatf("%s.wr%0d.adr", tag, i), got_adr[i], exp_adr[i]);
            chk($sformatf("%s.wr%0d.wdt", tag, i), got_wdt[i], exp_wdt[i]);
        end
        if (got_n.size() > 0 && exp_adr.size() > 0)
            chk($sformatf("%s.first_wr_cycle", tag), got_n[0], fb + 1);
        if (e_run)
            chk($sformatf("%s.ctrl_reg", tag), regs[0], e_done ? DW_MD'(m_en) : '0);
        if (g_done) begin
            tick();
            chk($sformatf("%s.done_one_cycle", tag), done, 0);
        end
    endtask

    typedef struct {
        logic [DW_MD-1:0] w;
        logic [DW_MD-1:0] h;
        bit               en;
        int               fb;
        bit               cor;
        bit               e_done;
        bit               e_err;
        logic [1:0]       e_code;
        int               e_lat;
    } vec_t;

    vec_t tbl [9];

    initial begin
        bit g_done;
        int g_lat;
        int busy_hits;
        logic [DW_MD-1:0] rw, rh;

        tbl[0] = '{16'd640, 16'd480, 1'b1,  0, 1'b0, 1'b1, 1'b0, 2'd0, 13};
        tbl[1] = '{16'd640, 16'd480, 1'b1, 50, 1'b0, 1'b1, 1'b0, 2'd0, 63};
        tbl[2] = '{16'd0,   16'd480, 1'b1,  0, 1'b0, 1'b0, 1'b1, 2'd1,  0};
        tbl[3] = '{16'd320, 16'd240, 1'b1,  0, 1'b0, 1'b1, 1'b0, 2'd0, 13};
        tbl[4] = '{16'd100, 16'd481, 1'b0,  0, 1'b0, 1'b0, 1'b1, 2'd1,  0};
        tbl[5] = '{16'd320, 16'd240, 1'b0,  0, 1'b0, 1'b1, 1'b0, 2'd0, 13};
        tbl[6] = '{16'd640, 16'd480, 1'b1,  0, 1'b1, 1'b0, 1'b1, 2'd2, 27};
        tbl[7] = '{16'd641, 16'd1,   1'b1,  0, 1'b0, 1'b0, 1'b1, 2'd1,  0};
        tbl[8] = '{16'd1,   16'd1,   1'b1,  2, 1'b0, 1'b1, 1'b0, 2'd0, 15};

        rst = 1; cfg_req = 0; cfg_width = 0; cfg_height = 0; cfg_en = 0;
        frame_busy = 0; filt_error = 0; corrupt = 0;
        model_reset();
        repeat (3) tick();
        chk("reset.outputs", {busy, done, cfg_err, err_code, mb.val, mb.adr, mb.wdt}, 0);
        rst = 0;
        tick();

        for (int i = 0; i < 9; i++) begin
            do_case($sformatf("tbl%0d", i), 1'b1, 1'b0, tbl[i].w, tbl[i].h, tbl[i].en,
                    tbl[i].fb, tbl[i].cor, g_done, g_lat);
            chk($sformatf("tbl%0d.exp_done", i), g_done, tbl[i].e_done);
            chk($sformatf("tbl%0d.exp_latency", i), g_lat, tbl[i].e_lat);
            chk($sformatf("tbl%0d.exp_err", i), cfg_err, tbl[i].e_err);
            chk($sformatf("tbl%0d.exp_code", i), err_code, tbl[i].e_code);
        end

        // Auto-recovery replays the stored geometry.
        do_case("setup", 1'b1, 1'b0, 16'd640, 16'd480, 1'b1, 0, 1'b0, g_done, g_lat);
        do_case("recover", 1'b0, 1'b1, 16'd5, 16'd5, 1'b0, 0, 1'b0, g_done, g_lat);
        chk("recover.done_const", g_done, 1);
        // A legal request coinciding with a filter error wins.
        do_case("req_vs_err", 1'b1, 1'b1, 16'd200, 16'd100, 1'b0, 0, 1'b0, g_done, g_lat);

        // Randomized requests and error pulses.
        for (int i = 0; i < 40; i++) begin
            rw = ($urandom % 4 == 0) ? DW_MD'($urandom_range(0, 700)) : DW_MD'($urandom_range(1, 640));
            rh = ($urandom % 4 == 0) ? DW_MD'($urandom_range(0, 520)) : DW_MD'($urandom_range(1, 480));
            do_case($sformatf("rnd%0d", i), ($urandom % 5) != 0, ($urandom % 3) == 0, rw, rh,
                    1'($urandom), $urandom_range(0, 3), ($urandom % 6) == 0, g_done, g_lat);
        end

        // Asynchronous reset in the middle of the height write.
        corrupt = 0;
        cfg_req = 1; cfg_width = 640; cfg_height = 480; cfg_en = 1;
        tick();
        cfg_req = 0;
        begin
            int k;
            k = 0;
            while (!(mb.val && mb.adr == 8'd2) && k < 40) begin
                tick();
                k++;
            end
            chk("midrst.reached_wr_h", k < 40, 1);
        end
        #1 rst = 1;
        #1;
        chk("midrst.outputs", {busy, done, cfg_err, err_code, mb.val, mb.adr, mb.wdt}, 0);
        tick();
        rst = 0;
        model_reset();
        filt_error = 1;
        busy_hits = 0;
        repeat (5) begin
            tick();
            if (busy) busy_hits++;
        end
        filt_error = 0;
        tick();
        chk("midrst.no_recovery", busy_hits, 0);
        do_case("post_rst", 1'b1, 1'b0, 16'd64, 16'd48, 1'b1, 0, 1'b0, g_done, g_lat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
